// File: rtl/uart_tx_sched.sv
// UART TX scheduler: round-robin between two requesters, byte sequencing.
// Optional BUSY-rise timeout enabled by define UART_SCHED_TIMEOUT_EN.
module uart_tx_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int BUSY_WAIT  = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    REQ0_VALID,
  input  logic [2*DATA_WIDTH-1:0] REQ0_DATA,
  input  logic                    REQ0_LEN,
  output logic                    REQ0_READY,
  input  logic                    REQ1_VALID,
  input  logic [2*DATA_WIDTH-1:0] REQ1_DATA,
  input  logic                    REQ1_LEN,
  output logic                    REQ1_READY,
  input  logic                    TX_BUSY,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_DATA_VALID,
  output logic                    SCHED_BUSY,
  output logic                    GRANT_ID,
  output logic                    TX_ERR
);

  localparam int PW = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_HI,
    WAIT_LO
  } state_e;

  state_e                  state_q;
  logic                    ptr_q;
  logic [PW-1:0]           data_q;
  logic                    len_q;
  logic                    hi_sel_q;
  logic                    rdy0_q;
  logic                    rdy1_q;
  logic [DATA_WIDTH-1:0]   pdata_q;
  logic                    dv_q;
  logic                    busy_q;
  logic                    gid_q;

  logic                    gnt_any_d;
  logic                    gnt_id_d;
  logic [PW-1:0]           gnt_data_d;
  logic                    gnt_len_d;
  logic [DATA_WIDTH-1:0]   cur_byte_d;

`ifdef UART_SCHED_TIMEOUT_EN
  localparam int CW = (BUSY_WAIT < 2) ? 1 : $clog2(BUSY_WAIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_WAIT - 1);
  logic [CW-1:0]           cnt_q;
  logic                    err_q;
`endif

  // Arbitration: ptr_q names the requester favoured when both are valid.
  always_comb begin
    gnt_any_d  = REQ0_VALID | REQ1_VALID;
    gnt_id_d   = (REQ0_VALID & REQ1_VALID) ? ptr_q : REQ1_VALID;
    gnt_data_d = gnt_id_d ? REQ1_DATA : REQ0_DATA;
    gnt_len_d  = gnt_id_d ? REQ1_LEN : REQ0_LEN;
    cur_byte_d = hi_sel_q ? data_q[PW-1:DATA_WIDTH]
                          : data_q[DATA_WIDTH-1:0];
  end

  // Scheduler FSM; every output is a register updated here.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      data_q   <= '0;
      len_q    <= 1'b0;
      hi_sel_q <= 1'b0;
      rdy0_q   <= 1'b0;
      rdy1_q   <= 1'b0;
      pdata_q  <= '0;
      dv_q     <= 1'b0;
      busy_q   <= 1'b0;
      gid_q    <= 1'b0;
`ifdef UART_SCHED_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      rdy0_q <= 1'b0;
      rdy1_q <= 1'b0;
      dv_q   <= 1'b0;
`ifdef UART_SCHED_TIMEOUT_EN
      err_q  <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (gnt_any_d) begin
            data_q   <= gnt_data_d;
            len_q    <= gnt_len_d;
            hi_sel_q <= 1'b0;
            gid_q    <= gnt_id_d;
            rdy0_q   <= ~gnt_id_d;
            rdy1_q   <= gnt_id_d;
            ptr_q    <= ~gnt_id_d;
            busy_q   <= 1'b1;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          if (!TX_BUSY) begin
            pdata_q <= cur_byte_d;
            dv_q    <= 1'b1;
            state_q <= WAIT_HI;
`ifdef UART_SCHED_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        WAIT_HI: begin
          if (TX_BUSY) begin
            state_q <= WAIT_LO;
          end
`ifdef UART_SCHED_TIMEOUT_EN
          else if (cnt_q == CNT_LAST) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
`endif
        end
        WAIT_LO: begin
          if (!TX_BUSY) begin
            if (len_q && !hi_sel_q) begin
              hi_sel_q <= 1'b1;
              state_q  <= ISSUE;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign REQ0_READY    = rdy0_q;
  assign REQ1_READY    = rdy1_q;
  assign TX_P_DATA     = pdata_q;
  assign TX_DATA_VALID = dv_q;
  assign SCHED_BUSY    = busy_q;
  assign GRANT_ID      = gid_q;
`ifdef UART_SCHED_TIMEOUT_EN
  assign TX_ERR        = err_q;
`else
  assign TX_ERR        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a small UART BUSY model.
// Expected bytes, grants and timings are hand-derived constants.
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        RST = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [15:0] d0 = '0, d1 = '0;
  logic        l0 = 1'b0, l1 = 1'b0;
  logic        REQ0_READY, REQ1_READY;
  logic        tx_busy = 1'b0;
  logic [7:0]  TX_P_DATA;
  logic        TX_DATA_VALID, SCHED_BUSY, GRANT_ID, TX_ERR;

  int checks = 0;
  int errors = 0;

  logic [7:0] byte_log[$];
  bit         grant_log[$];
  int         cyc = 0;
  int         strobe_cyc = 0;
  int         err_cyc = 0;
  int         err_cnt = 0;
  int         sw_busy = 0;
  int         mcnt = 0;
  int         busy_len = 11;
  bit         model_en = 1'b1;
  bit         force_hi = 1'b0;

  uart_tx_sched #(.DATA_WIDTH(8), .BUSY_WAIT(4)) dut (
    .CLK(clk), .RST(RST),
    .REQ0_VALID(v0), .REQ0_DATA(d0), .REQ0_LEN(l0), .REQ0_READY(REQ0_READY),
    .REQ1_VALID(v1), .REQ1_DATA(d1), .REQ1_LEN(l1), .REQ1_READY(REQ1_READY),
    .TX_BUSY(tx_busy), .TX_P_DATA(TX_P_DATA), .TX_DATA_VALID(TX_DATA_VALID),
    .SCHED_BUSY(SCHED_BUSY), .GRANT_ID(GRANT_ID), .TX_ERR(TX_ERR)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor and UART BUSY model, both on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (TX_DATA_VALID) begin
      if (tx_busy) sw_busy++;
      byte_log.push_back(TX_P_DATA);
      strobe_cyc = cyc;
    end
    if (REQ0_READY) grant_log.push_back(1'b0);
    if (REQ1_READY) grant_log.push_back(1'b1);
    if (TX_ERR) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (RST) mcnt = 0;
    else if (TX_DATA_VALID && model_en) mcnt = busy_len;
    else if (mcnt != 0) mcnt--;
    tx_busy = (mcnt != 0) || force_hi;
  end

  task automatic do_reset();
    @(negedge clk);
    RST = 1'b1;
    repeat (2) @(negedge clk);
    RST = 1'b0;
    byte_log.delete();
    grant_log.delete();
    sw_busy = 0;
    err_cnt = 0;
  endtask

  task automatic send(input bit id, input logic [15:0] d, input bit l);
    bit seen;
    seen = 1'b0;
    if (id) begin v1 = 1'b1; d1 = d; l1 = l; end
    else    begin v0 = 1'b1; d0 = d; l0 = l; end
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = id ? REQ1_READY : REQ0_READY;
    end
    chk("ready_seen", seen, 1);
    if (id) v1 = 1'b0;
    else    v0 = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 300 && !idle; i++) begin
      @(negedge clk);
      idle = !SCHED_BUSY;
    end
    chk("idle_reached", idle, 1);
  endtask

  initial begin
    int k;
    bit got1;
    #1 RST = 1'b1;
    #1;
    chk("rst_pdata", TX_P_DATA, 0);
    chk("rst_dv", TX_DATA_VALID, 0);
    chk("rst_rdy", {REQ0_READY, REQ1_READY}, 0);
    chk("rst_sbusy", SCHED_BUSY, 0);
    chk("rst_gid", GRANT_ID, 0);
    chk("rst_err", TX_ERR, 0);
    do_reset();

    // Single byte from REQ0.
    send(1'b0, 16'h00A5, 1'b0);
    chk("t1_sbusy_on", SCHED_BUSY, 1);
    wait_idle();
    chk("t1_busy_low", tx_busy, 0);
    chk("t1_grants", grant_log.size(), 1);
    chk("t1_nbytes", byte_log.size(), 1);
    chk("t1_byte", byte_log[0], 8'hA5);
    chk("t1_gid", GRANT_ID, 0);

    // Two bytes from REQ1, low first.
    byte_log.delete();
    send(1'b1, 16'h3C5A, 1'b1);
    wait_idle();
    chk("t2_nbytes", byte_log.size(), 2);
    chk("t2_b0", byte_log[0], 8'h5A);
    chk("t2_b1", byte_log[1], 8'h3C);
    chk("t2_gid", GRANT_ID, 1);
    chk("t2_no_busy_strobe", sw_busy, 0);

    // Lone requester served back-to-back.
    grant_log.delete();
    send(1'b1, 16'h0001, 1'b0);
    wait_idle();
    send(1'b1, 16'h0002, 1'b0);
    wait_idle();
    chk("lone_n", grant_log.size(), 2);
    chk("lone_g", {grant_log[0], grant_log[1]}, 2'b11);

    // Round robin from reset with both requesters valid.
    do_reset();
    d0 = 16'h0011; l0 = 1'b0;
    d1 = 16'h0022; l1 = 1'b0;
    v0 = 1'b1; v1 = 1'b1;
    k = 0;
    for (int c = 0; c < 2000 && k < 4; c++) begin
      @(negedge clk);
      if (REQ0_READY || REQ1_READY) begin
        chk("rr_gid", GRANT_ID, k % 2);
        chk("rr_rdy1", REQ1_READY, k % 2);
        k++;
        if (k == 3) v0 = 1'b0;
        if (k == 4) v1 = 1'b0;
      end
    end
    v0 = 1'b0; v1 = 1'b0;
    chk("rr_count", k, 4);
    wait_idle();
    chk("rr_nbytes", byte_log.size(), 4);
    chk("rr_bytes", {byte_log[0], byte_log[1], byte_log[2], byte_log[3]},
        32'h11221122);

    // BUSY held while the scheduler is in ISSUE.
    byte_log.delete();
    sw_busy = 0;
    force_hi = 1'b1;
    send(1'b1, 16'h0077, 1'b0);
    repeat (20) @(negedge clk);
    chk("hold_nbytes", byte_log.size(), 0);
    chk("hold_sbusy", SCHED_BUSY, 1);
    force_hi = 1'b0;
    wait_idle();
    chk("hold_after", byte_log.size(), 1);
    chk("hold_byte", byte_log[0], 8'h77);
    chk("hold_no_busy_strobe", sw_busy, 0);

    // Reset during WAIT_LO of the first byte of a two-byte frame.
    byte_log.delete();
    send(1'b1, 16'hBEEF, 1'b1);
    got1 = 1'b0;
    for (int i = 0; i < 50 && !got1; i++) begin
      @(negedge clk);
      got1 = (byte_log.size() == 1);
    end
    chk("mid_first", got1, 1);
    repeat (3) @(negedge clk);
    chk("mid_pre_sbusy", SCHED_BUSY, 1);
    #2 RST = 1'b1;
    #1;
    chk("mid_pdata", TX_P_DATA, 0);
    chk("mid_sbusy", SCHED_BUSY, 0);
    chk("mid_gid", GRANT_ID, 0);
    @(negedge clk);
    RST = 1'b0;
    repeat (40) @(negedge clk);
    chk("mid_nbytes", byte_log.size(), 1);
    chk("mid_byte", byte_log[0], 8'hEF);
    chk("mid_idle", SCHED_BUSY, 0);

    // BUSY never rises after the strobe.
    do_reset();
    model_en = 1'b0;
    send(1'b0, 16'h0011, 1'b0);
    repeat (20) @(negedge clk);
    chk("to_nbytes", byte_log.size(), 1);
`ifdef UART_SCHED_TIMEOUT_EN
    chk("to_errcnt", err_cnt, 1);
    chk("to_delay", err_cyc - strobe_cyc, 4);
    chk("to_sbusy", SCHED_BUSY, 0);
`else
    chk("to_sbusy", SCHED_BUSY, 1);
    chk("to_errcnt", err_cnt, 0);
    chk("to_err", TX_ERR, 0);
`endif
    model_en = 1'b1;
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Scheduler in front of the UART transmitter; shares the single TX path between two requesters (register-file read-back and ALU result).
- Round-robin arbitration between the requesters; captures one request at a time.
- Splits a 16-bit payload into bytes, low byte first.
- Drives the transmitter's P_DATA/DATA_VALID and sequences bytes against its BUSY flag.

Parameters:
- DATA_WIDTH, 8, byte width presented to the UART TX.
- BUSY_WAIT, 4, max cycles between DATA_VALID and BUSY rising (used only with the optional feature).

Ports:
- CLK  in  1  system clock; single clock domain.
- RST  in  1  asynchronous, active-high reset.
- REQ0_VALID  in  1  requester 0 has a payload.
- REQ0_DATA  in  2*DATA_WIDTH  requester 0 payload.
- REQ0_LEN  in  1  0 = send low byte only, 1 = send both bytes.
- REQ0_READY  out  1  one-cycle accept pulse to requester 0.
- REQ1_VALID  in  1  requester 1 has a payload.
- REQ1_DATA  in  2*DATA_WIDTH  requester 1 payload.
- REQ1_LEN  in  1  same encoding as REQ0_LEN.
- REQ1_READY  out  1  one-cycle accept pulse to requester 1.
- TX_BUSY  in  1  BUSY from the UART TX.
- TX_P_DATA  out  DATA_WIDTH  byte to the UART TX.
- TX_DATA_VALID  out  1  one-cycle strobe to the UART TX.
- SCHED_BUSY  out  1  high whenever the FSM is not in IDLE.
- GRANT_ID  out  1  requester currently or last served.
- TX_ERR  out  1  one-cycle abort pulse.

Behaviour:
- Reset values (asynchronous, on RST high): all outputs 0, FSM = IDLE, round-robin pointer favours REQ0, holding registers cleared.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT_HI, WAIT_LO.
- IDLE arbitration:
  - Only one valid: grant it.
  - Both valid: grant the one not granted last.
  - On grant, on the same clock edge: latch DATA and LEN into the holding register, set GRANT_ID, pulse the granted READY high for exactly one cycle, set SCHED_BUSY, go to ISSUE.
  - The requester drops VALID or presents a new payload after its READY pulse.
- ISSUE:
  - If TX_BUSY = 0: drive TX_P_DATA with the current byte (low byte first, then high), pulse TX_DATA_VALID for one cycle, go to WAIT_HI.
  - If TX_BUSY = 1: hold in ISSUE.
- WAIT_HI:
  - TX_DATA_VALID = 0; TX_P_DATA held stable.
  - Go to WAIT_LO on TX_BUSY = 1.
- WAIT_LO:
  - On TX_BUSY = 0: if LEN = 1 and the high byte is not yet sent, select the high byte and go to ISSUE.
  - Otherwise go to IDLE and clear SCHED_BUSY.
- Latency:
  - REQ_VALID sampled in IDLE → READY on the next edge.
  - First TX_DATA_VALID one cycle later at the earliest, if TX_BUSY = 0.
  - The second byte's TX_DATA_VALID comes no earlier than one cycle after TX_BUSY falls.
- REQ_VALID is ignored outside IDLE. No READY is issued and the request stays pending.
- Pointer update: the pointer flips to "favour the other requester" only on a grant. A lone requester may be served back-to-back.
- Return to IDLE and a new arbitration may occur in consecutive cycles; no dead cycle is required beyond the FSM transitions above.
- RST mid-frame: abort immediately to reset values; no further TX_DATA_VALID is issued. The UART TX is reset by the same RST.
- TX_ERR:
  - Without the optional feature, TX_ERR is constant 0.

Optional Feature:
- Macro: UART_SCHED_TIMEOUT_EN.
- Defined:
  - A counter starts on entry to WAIT_HI.
  - If TX_BUSY is not seen high within BUSY_WAIT cycles, the remaining bytes of the frame are discarded.
  - TX_ERR pulses for one cycle, the FSM goes to IDLE, and the pointer still advances.
- Not defined:
  - WAIT_HI waits indefinitely.
  - No counter logic is synthesised; TX_ERR is tied to 0.

Test Plan:
- Reset → all outputs 0. Then REQ0_VALID=1, DATA=16'h00A5, LEN=0, with a UART model holding BUSY for 11 cycles → REQ0_READY one pulse; one TX_DATA_VALID with TX_P_DATA=8'hA5; SCHED_BUSY falls after BUSY falls.
- REQ1 DATA=16'h3C5A, LEN=1 → two strobes, 8'h5A then 8'h3C. The second strobe occurs only after BUSY has fallen.
- REQ0 and REQ1 both held valid for 4 frames from reset → GRANT_ID sequence 0,1,0,1; READY pulses alternate.
- TX_BUSY held 1 while in ISSUE for 20 cycles → no TX_DATA_VALID until BUSY falls, then exactly one strobe.
- Assert RST in WAIT_LO of the first byte of a 2-byte frame → outputs 0 asynchronously; no second byte sent after release.
- With UART_SCHED_TIMEOUT_EN, BUSY_WAIT=4, TX_BUSY stuck 0 → TX_ERR pulse 4 cycles after the strobe, FSM back in IDLE. Without the macro: SCHED_BUSY stays 1 and TX_ERR stays 0.
